qpsk_symbol_receiver: RTL and testbench

- Streaming receive-side QPSK slicer and byte assembler for the audio link; sits after the noisy-channel model.
- Accepts one signed I/Q sample pair per cycle over a valid/ready handshake and makes a hard sign decision per axis.
- Packs four symbols into a data byte, flags weak (low-magnitude) decisions, and presents bytes downstream over a second valid/ready handshake.
- Complements the parallel four-symbol `Modulation`/`Demodulation` pair by handling the serialized, back-pressured symbol stream.

---
 rtl/qpsk_symbol_receiver.sv | 178 +++++++++++++++++
 tb/tb_qpsk_symbol_receiver.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_receiver.sv
// qpsk_symbol_receiver
// Streaming QPSK hard-decision slicer and byte assembler. Accepts one signed
// I/Q pair per cycle, packs four symbols into a byte (symbol k -> bits
// [2k+1:2k], I on the odd bit, Q on the even bit), tracks low-magnitude
// decisions, and delivers bytes through a two-deep output stage (OUT + PEND).
module qpsk_symbol_receiver #(
    parameter int WIDTH  = 16,
    parameter int THRESH = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    input  logic                    sym_first,
    input  logic signed [WIDTH-1:0] sym_i,
    input  logic signed [WIDTH-1:0] sym_q,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic [7:0]              byte_data,
    output logic                    byte_weak,
    output logic [15:0]             sync_err_count
);

    localparam logic [WIDTH:0] THRESH_W = (WIDTH+1)'(THRESH);

    // Magnitude at WIDTH+1 bits so the most negative sample maps to 2^(WIDTH-1).
    function automatic logic [WIDTH:0] sample_mag(input logic signed [WIDTH-1:0] s);
        logic [WIDTH:0] ext;
        ext = {s[WIDTH-1], s};
        if (s[WIDTH-1]) begin
            sample_mag = ~ext + (WIDTH+1)'(1);
        end else begin
            sample_mag = ext;
        end
    endfunction

    // Assembly state
    logic [1:0]  cnt_q,  cnt_d;
    logic [7:0]  asm_q,  asm_d;
    logic        weak_q, weak_d;
    logic [15:0] err_q,  err_d;

    // Output stages
    logic        out_valid_q,  out_valid_d;
    logic [7:0]  out_data_q,   out_data_d;
    logic        out_weak_q,   out_weak_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_data_q,  pend_data_d;
    logic        pend_weak_q,  pend_weak_d;
    logic        sym_ready_q,  sym_ready_d;

    // Per-symbol decode
    logic        accept_s;
    logic        out_drain_s;
    logic [1:0]  eff_k_s;
    logic        bit_i_s, bit_q_s;
    logic        weak_i_s, weak_q_s;
    logic [7:0]  asm_new_s;
    logic        weak_new_s;
    logic        complete_s;

    assign accept_s    = sym_valid && sym_ready_q;
    assign out_drain_s = out_valid_q && byte_ready;

    // Slice the incoming pair and merge it into the byte under assembly.
    always_comb begin
        eff_k_s    = sym_first ? 2'd0 : cnt_q;
        bit_i_s    = sym_i[WIDTH-1];
        bit_q_s    = sym_q[WIDTH-1];
        weak_i_s   = sample_mag(sym_i) < THRESH_W;
        weak_q_s   = sample_mag(sym_q) < THRESH_W;
        if (eff_k_s == 2'd0) begin
            asm_new_s  = 8'h00;
            weak_new_s = 1'b0;
        end else begin
            asm_new_s  = asm_q;
            weak_new_s = weak_q;
        end
        asm_new_s[{eff_k_s, 1'b1}] = bit_i_s;
        asm_new_s[{eff_k_s, 1'b0}] = bit_q_s;
        weak_new_s = weak_new_s | weak_i_s | weak_q_s;
        complete_s = accept_s && (eff_k_s == 2'd3);
    end

    // Next state for the symbol counter, assembly register and sync-error counter.
    always_comb begin
        cnt_d  = cnt_q;
        asm_d  = asm_q;
        weak_d = weak_q;
        err_d  = err_q;
        if (accept_s) begin
            cnt_d = eff_k_s + 2'd1;
            asm_d = asm_new_s;
            if (complete_s) begin
                weak_d = 1'b0;
            end else begin
                weak_d = weak_new_s;
            end
            if (sym_first && (cnt_q != 2'd0) && (err_q != 16'hFFFF)) begin
                err_d = err_q + 16'd1;
            end else begin
                err_d = err_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Next state for the OUT/PEND stages; PEND always has priority into OUT.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_weak_d   = out_weak_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_weak_d  = pend_weak_q;
        if (!out_valid_q || out_drain_s) begin
            if (pend_valid_q) begin
                // sym_ready is low here, so no byte can complete this cycle.
                out_valid_d  = 1'b1;
                out_data_d   = pend_data_q;
                out_weak_d   = pend_weak_q;
                pend_valid_d = 1'b0;
            end else if (complete_s) begin
                out_valid_d = 1'b1;
                out_data_d  = asm_new_s;
                out_weak_d  = weak_new_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (complete_s) begin
                pend_valid_d = 1'b1;
                pend_data_d  = asm_new_s;
                pend_weak_d  = weak_new_s;
            end else begin
                pend_valid_d = pend_valid_q;
            end
        end
        sym_ready_d = !pend_valid_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 2'd0;
            asm_q        <= 8'h00;
            weak_q       <= 1'b0;
            err_q        <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_weak_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            pend_weak_q  <= 1'b0;
            sym_ready_q  <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            weak_q       <= weak_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_weak_q   <= out_weak_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_weak_q  <= pend_weak_d;
            sym_ready_q  <= sym_ready_d;
        end
    end

    assign sym_ready      = sym_ready_q;
    assign byte_valid     = out_valid_q;
    assign byte_data      = out_data_q;
    assign byte_weak      = out_weak_q;
    assign sync_err_count = err_q;

endmodule

// File: tb/tb_qpsk_symbol_receiver.sv
// Testbench for qpsk_symbol_receiver: scoreboard of expected bytes, popped by
// a monitor whenever the DUT hands over a byte.
module tb_qpsk_symbol_receiver;

    localparam logic signed [15:0] POS = 16'sd8192;
    localparam logic signed [15:0] NEG = -16'sd8192;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sym_valid = 1'b0;
    logic               sym_ready;
    logic               sym_first = 1'b0;
    logic signed [15:0] sym_i = 16'sd0;
    logic signed [15:0] sym_q = 16'sd0;
    logic               byte_valid;
    logic               byte_ready = 1'b0;
    logic [7:0]         byte_data;
    logic               byte_weak;
    logic [15:0]        sync_err_count;

    typedef struct packed {
        logic [7:0] d;
        logic       w;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;
    int   popped = 0;

    logic       hold = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_w = 1'b0;

    qpsk_symbol_receiver #(.WIDTH(16), .THRESH(4096)) dut (
        .clk            (clk),
        .reset          (reset),
        .sym_valid      (sym_valid),
        .sym_ready      (sym_ready),
        .sym_first      (sym_first),
        .sym_i          (sym_i),
        .sym_q          (sym_q),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .byte_data      (byte_data),
        .byte_weak      (byte_weak),
        .sync_err_count (sync_err_count)
    );

    always #5 clk = ~clk;

    // Monitor: pop the scoreboard on each handshake and check output stability under backpressure.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                checks++;
                if (byte_valid !== 1'b1 || byte_data !== hold_d || byte_weak !== hold_w) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b data=%h weak=%b, need valid=1 data=%h weak=%b",
                             byte_valid, byte_data, byte_weak, hold_d, hold_w);
                end
            end
            if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
                checks++;
                popped++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got data=%h weak=%b, none expected", byte_data, byte_weak);
                end else begin
                    e = sb.pop_front();
                    if (byte_data !== e.d || byte_weak !== e.w) begin
                        errors++;
                        $display("FAIL byte_out: got data=%h weak=%b, need data=%h weak=%b",
                                 byte_data, byte_weak, e.d, e.w);
                    end
                end
                hold = 1'b0;
            end else if (byte_valid === 1'b1) begin
                hold   = 1'b1;
                hold_d = byte_data;
                hold_w = byte_weak;
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic send_sym(input logic signed [15:0] i, input logic signed [15:0] q, input logic first);
        int n;
        @(negedge clk);
        sym_valid = 1'b1;
        sym_i     = i;
        sym_q     = q;
        sym_first = first;
        n = 0;
        while (sym_ready !== 1'b1 && n < 100) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL sym_ready_timeout: got sym_ready=%b, need 1", sym_ready);
        end
        @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic use_first);
        for (int k = 0; k < 4; k++) begin
            send_sym(b[2*k+1] ? NEG : POS, b[2*k] ? NEG : POS, use_first && (k == 0));
        end
    endtask

    task automatic idle();
        @(negedge clk);
        sym_valid = 1'b0;
        sym_first = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 byte_ready = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        sym_valid = 1'b0;
        sym_first = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || byte_valid === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d bytes still outstanding, need 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (sym_ready !== 1'b1) begin errors++; $display("FAIL reset_sym_ready: got %b, need 1", sym_ready); end
        checks++;
        if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: got %b, need 0", byte_valid); end
        checks++;
        if (sync_err_count !== 16'h0000) begin errors++; $display("FAIL reset_sync_err: got %h, need 0000", sync_err_count); end
        checks++;
        if (byte_data !== 8'h00 || byte_weak !== 1'b0) begin
            errors++;
            $display("FAIL reset_byte: got data=%h weak=%b, need 00/0", byte_data, byte_weak);
        end
    endtask

    task automatic test_single_byte();
        set_ready(1'b1);
        sb.push_back('{d: 8'hB4, w: 1'b0});
        send_sym(POS, POS, 1'b1);
        send_sym(POS, NEG, 1'b0);
        send_sym(NEG, NEG, 1'b0);
        send_sym(NEG, POS, 1'b0);
        @(negedge clk);
        checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hB4 || byte_weak !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got valid=%b data=%h weak=%b, need 1/B4/0",
                     byte_valid, byte_data, byte_weak);
        end
        sym_valid = 1'b0;
        wait_drain("single");
    endtask

    task automatic test_sweep();
        int p0;
        stalls = 0;
        p0 = popped;
        for (int b = 0; b < 256; b++) begin
            sb.push_back('{d: 8'(b), w: 1'b0});
            send_byte(8'(b), 1'b1);
        end
        idle();
        wait_drain("sweep");
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL sweep_stalls: got %0d, need 0", stalls); end
        checks++;
        if (popped - p0 != 256) begin errors++; $display("FAIL sweep_count: got %0d, need 256", popped - p0); end
    endtask

    task automatic test_weak();
        sb.push_back('{d: 8'h00, w: 1'b1});
        send_sym(POS, POS, 1'b1);
        send_sym(POS, POS, 1'b0);
        send_sym(POS, 16'sd100, 1'b0);
        send_sym(POS, POS, 1'b0);
        sb.push_back('{d: 8'h01, w: 1'b0});
        send_sym(POS, -16'sd32768, 1'b1);
        send_sym(POS, POS, 1'b0);
        send_sym(POS, POS, 1'b0);
        send_sym(POS, POS, 1'b0);
        sb.push_back('{d: 8'h01, w: 1'b0});
        send_sym(16'sd4096, -16'sd4096, 1'b1);
        send_sym(POS, POS, 1'b0);
        send_sym(POS, POS, 1'b0);
        send_sym(POS, POS, 1'b0);
        sb.push_back('{d: 8'h80, w: 1'b1});
        send_sym(POS, POS, 1'b1);
        send_sym(POS, POS, 1'b0);
        send_sym(POS, POS, 1'b0);
        send_sym(-16'sd4095, POS, 1'b0);
        idle();
        wait_drain("weak");
    endtask

    task automatic test_sync_error();
        do_reset();
        set_ready(1'b1);
        send_sym(NEG, NEG, 1'b1);
        send_sym(POS, NEG, 1'b0);
        sb.push_back('{d: 8'h5A, w: 1'b0});
        send_byte(8'h5A, 1'b1);
        idle();
        wait_drain("sync");
        checks++;
        if (sync_err_count !== 16'd1) begin
            errors++;
            $display("FAIL sync_err_count: got %0d, need 1", sync_err_count);
        end
    endtask

    task automatic test_backpressure();
        set_ready(1'b0);
        sb.push_back('{d: 8'hC3, w: 1'b0});
        sb.push_back('{d: 8'h0F, w: 1'b0});
        send_byte(8'hC3, 1'b1);
        send_byte(8'h0F, 1'b1);
        @(negedge clk);
        sym_valid = 1'b0;
        checks++;
        if (sym_ready !== 1'b0 || byte_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: got sym_ready=%b byte_valid=%b, need 0/1", sym_ready, byte_valid);
        end
        repeat (4) @(negedge clk);
        set_ready(1'b1);
        wait_drain("bp");
        @(negedge clk);
        checks++;
        if (sym_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got sym_ready=%b, need 1", sym_ready); end
    endtask

    task automatic test_reset_discard();
        set_ready(1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle();
        do_reset();
        @(negedge clk);
        checks++;
        if (byte_valid !== 1'b0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_discard: got byte_valid=%b sym_ready=%b, need 0/1", byte_valid, sym_ready);
        end
        set_ready(1'b1);
        send_sym(NEG, NEG, 1'b1);
        send_sym(NEG, NEG, 1'b0);
        idle();
        do_reset();
        sb.push_back('{d: 8'h3C, w: 1'b0});
        send_byte(8'h3C, 1'b0);
        idle();
        wait_drain("rst_mid");
        checks++;
        if (sync_err_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_sync_err: got %0d, need 0", sync_err_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_sweep();
        test_weak();
        test_sync_error();
        test_backpressure();
        test_reset_discard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
